// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises {cmd, payload} frames for the RAM and shifts read data out on MISO.
// Optional `SPI_FRAME_ERR_EN adds a frame_err pulse for frames aborted by ss_n before completion.
module spi_slave_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ss_n,
  input  logic            mosi,
  output logic            miso,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam int CNT_W = $clog2(RX_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Sub-phase of a frame once its type is known.
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_TX,
    PH_HOLD
  } phase_t;

  state_t            state, state_nxt;
  phase_t            phase;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rd_addr_done;
  logic [RX_W-2:0]   rx_shift;
  logic [TX_W-2:0]   tx_shift;
  logic              abort;

  assign abort = ss_n && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!ss_n) state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!mosi)             state_nxt = WRITE;
          else if (rd_addr_done) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= PH_RX;
      bit_cnt      <= '0;
      rd_addr_done <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (abort) begin
        phase   <= PH_RX;
        bit_cnt <= '0;
        miso    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err <= (phase != PH_HOLD);
`endif
      end else begin
        case (state)
          WRITE, READ_ADD, READ_DATA: begin
            case (phase)
              PH_RX: begin
                if (bit_cnt == CNT_W'(RX_W-1)) begin
                  rx_data  <= {rx_shift, mosi};
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
                  phase    <= (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                  if (state == READ_ADD) rd_addr_done <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              PH_WAIT: begin
                // Only the first tx_valid of the frame is taken.
                if (tx_valid) begin
                  miso    <= tx_data[TX_W-1];
                  bit_cnt <= '0;
                  phase   <= PH_TX;
                end
              end
              PH_TX: begin
                if (bit_cnt == CNT_W'(TX_W-1)) begin
                  miso         <= 1'b0;
                  rd_addr_done <= 1'b0;
                  phase        <= PH_HOLD;
                end else begin
                  miso    <= tx_shift[TX_W-2];
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              default: miso <= 1'b0;
            endcase
          end
          default: begin
            phase   <= PH_RX;
            bit_cnt <= '0;
            miso    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Shift registers carry data only; their contents are qualified by phase/bit_cnt.
  always_ff @(posedge clk) begin
    if (phase == PH_RX) rx_shift <= {rx_shift[RX_W-3:0], mosi};
    if (phase == PH_WAIT && tx_valid) tx_shift <= tx_data[TX_W-2:0];
    else if (phase == PH_TX)          tx_shift <= {tx_shift[TX_W-3:0], 1'b0};
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: frame-level reference model drives randomised SPI frames and checks every cycle.
// Build with SPI_FRAME_ERR_EN defined to also check frame_err.
module tb_spi_slave_if;

  logic       clk;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: the read-sequencing flag and last delivered word.
  bit         m_flag = 1'b0;
  logic [9:0] m_rx   = '0;

  spi_slave_if #(.RX_W(10), .TX_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // One frame of type ftype carrying word; read-data capture at edge 12+d.
  // abort_at: edge with ss_n=1 (-1 none); rst_at: edge after which rst_n pulses (-1 none).
  task automatic run_frame(input bit ftype, input logic [9:0] word, input int d,
                           input logic [7:0] txd, input int abort_at, input int rst_at,
                           input bit extra_pulse);
    bit rdd, ra, aborted, exp_rv, exp_miso, exp_err;
    int t_cap, last;
    rdd   = ftype && m_flag;
    ra    = ftype && !m_flag;
    t_cap = 12 + d;
    last  = rdd ? t_cap + 8 : 12;
    for (int e = 0; e <= last; e++) begin
      ss_n = (e == abort_at);
      if (e == 1)                 mosi = ftype;
      else if (e >= 2 && e <= 11) mosi = word[11-e];
      else                        mosi = 1'($urandom());
      tx_data = 8'($urandom());
      if (rdd && e == t_cap) begin
        tx_valid = 1'b1;
        tx_data  = txd;
      end else if (rdd && extra_pulse && e == t_cap + 3) begin
        tx_valid = 1'b1;
        tx_data  = ~txd;
      end else if (rdd && e >= 12 && e < t_cap) begin
        tx_valid = 1'b0;
      end else begin
        tx_valid = 1'($urandom());
      end
      @(posedge clk);
      #1;
      aborted = (e == abort_at);
      exp_err = 1'b0;
      if (aborted) begin
        exp_rv   = 1'b0;
        exp_miso = 1'b0;
        exp_err  = rdd ? 1'b1 : (e <= 11);
      end else begin
        exp_rv = (e == 11);
        if (e == 11) m_rx = word;
        if (e == 11 && ra) m_flag = 1'b1;
        exp_miso = (rdd && e >= t_cap && e <= t_cap + 7) ? txd[7-(e-t_cap)] : 1'b0;
        if (rdd && e == t_cap + 8) m_flag = 1'b0;
      end
      checks++;
      if (rx_valid !== exp_rv) begin
        errors++;
        $display("FAIL rx_valid edge %0d: got %b, required %b", e, rx_valid, exp_rv);
      end
      checks++;
      if (rx_data !== m_rx) begin
        errors++;
        $display("FAIL rx_data edge %0d: got %h, required %h", e, rx_data, m_rx);
      end
      checks++;
      if (miso !== exp_miso) begin
        errors++;
        $display("FAIL miso edge %0d: got %b, required %b", e, miso, exp_miso);
      end
`ifdef SPI_FRAME_ERR_EN
      checks++;
      if (frame_err !== exp_err) begin
        errors++;
        $display("FAIL frame_err edge %0d: got %b, required %b", e, frame_err, exp_err);
      end
`endif
      if (e == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        m_flag = 1'b0;
        m_rx   = '0;
        checks++;
        if ({miso, rx_valid, rx_data, dut.rd_addr_done} !== 13'b0) begin
          errors++;
          $display("FAIL async_reset: got miso=%b rx_valid=%b rx_data=%h flag=%b, required all 0",
                   miso, rx_valid, rx_data, dut.rd_addr_done);
        end
        #1 rst_n = 1'b1;
        aborted = 1'b1;
      end
      if (aborted) break;
    end
    // Mandatory idle edge between frames.
    ss_n     = 1'b1;
    mosi     = 1'($urandom());
    tx_valid = 1'($urandom());
    tx_data  = 8'($urandom());
    @(posedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0 || miso !== 1'b0 || rx_data !== m_rx) begin
      errors++;
      $display("FAIL idle_outputs: got rx_valid=%b miso=%b rx_data=%h, required 0 0 %h",
               rx_valid, miso, rx_data, m_rx);
    end
    checks++;
    if (dut.rd_addr_done !== m_flag) begin
      errors++;
      $display("FAIL rd_addr_done: got %b, required %b", dut.rd_addr_done, m_flag);
    end
`ifdef SPI_FRAME_ERR_EN
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err idle: got %b, required 0", frame_err);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (miso !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got miso=%b rx_valid=%b, required 0 0", miso, rx_valid);
    end
    checks++;
    if (rx_data !== 10'h000) begin
      errors++;
      $display("FAIL reset_rx_data: got %h, required 000", rx_data);
    end
    checks++;
    if (dut.rd_addr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flag: got %b, required 0", dut.rd_addr_done);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    bit flag_before;
    run_frame(1'b0, 10'h03C, 0, 8'h00, -1, -1, 1'b0);
    flag_before = m_flag;
    run_frame(1'b0, 10'h1A5, 0, 8'h00, -1, -1, 1'b0);
    checks++;
    if (dut.rd_addr_done !== flag_before) begin
      errors++;
      $display("FAIL write_keeps_flag: got %b, required %b", dut.rd_addr_done, flag_before);
    end
  endtask

  task automatic test_read_seq();
    run_frame(1'b1, 10'h23C, 0, 8'h00, -1, -1, 1'b0);
    run_frame(1'b1, 10'h300, 1, 8'hA5, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_frame(1'b0, 10'h2B7, 0, 8'h00, 7, -1, 1'b0);
    run_frame(1'b0, 10'h155, 0, 8'h00, -1, -1, 1'b0);
  endtask

  task automatic test_delayed_tx();
    if (!m_flag) run_frame(1'b1, 10'h211, 0, 8'h00, -1, -1, 1'b0);
    run_frame(1'b1, 10'h3C3, 4, 8'h5A, -1, -1, 1'b1);
  endtask

  task automatic test_reset_mid_tx();
    if (!m_flag) run_frame(1'b1, 10'h2F0, 0, 8'h00, -1, -1, 1'b0);
    // Capture at edge 13; MISO bit 3 is driven after edge 17.
    run_frame(1'b1, 10'h3FF, 1, 8'h3C, -1, 17, 1'b0);
    run_frame(1'b1, 10'h20F, 0, 8'h00, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      bit         ft;
      logic [9:0] w;
      int         d, ab;
      ft = 1'($urandom());
      w  = 10'($urandom());
      d  = $urandom_range(0, 5);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20 + d) : -1;
      run_frame(ft, w, d, 8'($urandom()), ab, -1, 1'($urandom()));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_seq();
    test_abort();
    test_delayed_tx();
    test_reset_mid_tx();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
